// File: rtl/vend_pkg.sv
// Shared constants and state type for the soda vending path.
// The accumulator and the dispensing stage both take their coin values and price from here.
package vend_pkg;

  localparam int PRICE = 20;

  localparam logic [4:0] NICKEL_C  = 5'd5;
  localparam logic [4:0] DIME_C    = 5'd10;
  localparam logic [4:0] QUARTER_C = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_VEND  = 2'd2
  } vend_state_e;

endpackage

// File: rtl/coin_decoder.sv
// Maps the three one-hot coin lines to a coin value.
// valid = exactly one line high; invalid = two or more lines high.
module coin_decoder
  import vend_pkg::*;
(
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  output logic [4:0] value,
  output logic       valid,
  output logic       invalid
);

  always_comb begin
    value = '0;
    case ({quarter, dime, nickel})
      3'b001:  value = NICKEL_C;
      3'b010:  value = DIME_C;
      3'b100:  value = QUARTER_C;
      default: value = '0;
    endcase
  end

  // Odd parity without all three high means exactly one line is set.
  assign valid   = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);
  assign invalid = (nickel & dime) | (nickel & quarter) | (dime & quarter);

endmodule

// File: rtl/coin_accumulator.sv
// Coin front end: accumulates credit below PRICE and presents the total for one cycle on a vend.
// Build option: define COIN_REFUND_EN to add the refund_i / refund_o cancel path.
module coin_accumulator #(
  parameter int PRICE     = vend_pkg::PRICE,
  parameter int DEPOSIT_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 nickel_i,
  input  logic                 dime_i,
  input  logic                 quarter_i,
`ifdef COIN_REFUND_EN
  input  logic                 refund_i,
  output logic [4:0]           refund_o,
`endif
  output logic [DEPOSIT_W-1:0] deposit_o,
  output logic [4:0]           credit_o,
  output logic                 ready_o,
  output logic                 coin_reject_o
);
  import vend_pkg::*;

  localparam logic [5:0] PRICE_W = 6'(PRICE);

  vend_state_e          state_q, state_d;
  logic [4:0]           coin_value;
  logic                 coin_valid, coin_invalid;
  logic [5:0]           sum;
  logic                 refund_req;
  logic [4:0]           credit_d;
  logic [DEPOSIT_W-1:0] deposit_d;
  logic                 reject_d;
`ifdef COIN_REFUND_EN
  logic [4:0]           refund_d;
`endif

  coin_decoder u_decoder (
    .nickel  (nickel_i),
    .dime    (dime_i),
    .quarter (quarter_i),
    .value   (coin_value),
    .valid   (coin_valid),
    .invalid (coin_invalid)
  );

  // Credit never exceeds 15 and the largest coin is 25, so 6 bits cannot overflow.
  assign sum = {1'b0, credit_o} + {1'b0, coin_value};

`ifdef COIN_REFUND_EN
  assign refund_req = refund_i & (state_q == S_ACCUM);
`else
  assign refund_req = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      credit_o      <= '0;
      deposit_o     <= '0;
      coin_reject_o <= 1'b0;
      ready_o       <= 1'b1;
`ifdef COIN_REFUND_EN
      refund_o      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      credit_o      <= credit_d;
      deposit_o     <= deposit_d;
      coin_reject_o <= reject_d;
      ready_o       <= (state_d != S_VEND);
`ifdef COIN_REFUND_EN
      refund_o      <= refund_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (refund_req)      state_d = S_IDLE;
        else if (coin_valid) state_d = (sum >= PRICE_W) ? S_VEND : S_ACCUM;
      end
      S_VEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d  = credit_o;
    deposit_d = '0;
    reject_d  = 1'b0;
`ifdef COIN_REFUND_EN
    refund_d  = '0;
`endif
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (refund_req) begin
          // Refund wins over any coin arriving in the same cycle.
          credit_d = '0;
          reject_d = coin_valid | coin_invalid;
`ifdef COIN_REFUND_EN
          refund_d = credit_o;
`endif
        end else if (coin_invalid) begin
          reject_d = 1'b1;
        end else if (coin_valid) begin
          if (sum >= PRICE_W) begin
            deposit_d = DEPOSIT_W'(sum);
            credit_d  = '0;
          end else begin
            credit_d  = sum[4:0];
          end
        end
      end
      S_VEND:  reject_d = coin_valid | coin_invalid;
      default: credit_d = '0;
    endcase
  end

endmodule
